// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: sizing defaults,
// the HALT sentinel word and the sequencer state encoding.
package instr_fetch_pkg;

  localparam int DEFAULT_DEPTH = 16;
  localparam int DEFAULT_AW    = 4;

  // Opcode 6'b111111 with all other fields zero marks the end of a program.
  localparam logic [31:0] HALT_WORD = 32'hFC00_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/instr_mem.sv
// Program storage: DEPTH x 32 register array, synchronous write port and
// combinational read port.
module instr_mem
  import instr_fetch_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = DEFAULT_AW
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  // NOTE: storage has no reset on purpose; clearing a register file costs a
  // wide reset fan-out and the loader always writes before a program runs.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch sequencer: issues one stored word per unstalled cycle
// from word 0 until the programmed length or a HALT word is reached.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = DEFAULT_AW
) (
  input  logic          SYS_clk,
  input  logic          SYS_reset,
  input  logic          load_we,
  input  logic [AW-1:0] load_addr,
  input  logic [31:0]   load_data,
  input  logic [AW:0]   prog_len,
  input  logic          start,
  input  logic          stall,
  output logic [31:0]   machineCode,
  output logic          instr_valid,
  output logic [31:0]   PC,
  output logic          busy,
  output logic          done
);

  state_e        state_q, state_d;
  logic [AW:0]   len_q, len_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [31:0]   code_q, code_d;
  logic [31:0]   pc_q, pc_d;
  logic          valid_q, valid_d;
  logic          busy_q, done_q;

  logic          mem_we;
  logic [AW-1:0] rd_addr;
  logic [31:0]   rd_data;
  logic [AW:0]   next_idx;
  logic [AW:0]   start_len;

  // Index is widened by one bit so i+1 == DEPTH compares correctly and never wraps.
  assign next_idx  = {1'b0, idx_q} + 1'b1;
  assign start_len = (prog_len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : prog_len;
  assign mem_we    = load_we && !start && (state_q != RUN);
  assign rd_addr   = (state_q == RUN) ? next_idx[AW-1:0] : '0;

  instr_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (SYS_clk),
    .we    (mem_we),
    .waddr (load_addr),
    .wdata (load_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  // NOTE: every variable gets its hold value first so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    code_d  = code_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          len_d = start_len;
          idx_d = '0;
          pc_d  = '0;
          if (start_len == '0 || rd_data == HALT_WORD) begin
            state_d = DONE;
            valid_d = 1'b0;
            code_d  = '0;
          end else begin
            state_d = RUN;
            valid_d = 1'b1;
            code_d  = rd_data;
          end
        end
      end
      RUN: begin
        if (!stall) begin
          if (next_idx < len_q && rd_data != HALT_WORD) begin
            idx_d  = next_idx[AW-1:0];
            code_d = rd_data;
            pc_d   = 32'(next_idx) << 2;
          end else begin
            state_d = DONE;
            valid_d = 1'b0;
            code_d  = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        code_d  = '0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge SYS_clk) begin
    if (SYS_reset) begin
      state_q <= IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      code_q  <= '0;
      pc_q    <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      code_q  <= code_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      busy_q  <= (state_d == RUN);
      done_q  <= (state_d == DONE);
    end
  end

  assign machineCode = code_q;
  assign instr_valid = valid_q;
  assign PC          = pc_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus randomized
// programs compared against a queue-based model of the issue sequence.
module tb_instr_fetch;
  import instr_fetch_pkg::*;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          SYS_clk;
  logic          SYS_reset;
  logic          load_we;
  logic [AW-1:0] load_addr;
  logic [31:0]   load_data;
  logic [AW:0]   prog_len;
  logic          start;
  logic          stall;
  logic [31:0]   machineCode;
  logic          instr_valid;
  logic [31:0]   PC;
  logic          busy;
  logic          done;

  int errors = 0;
  int checks = 0;
  logic [31:0] mem_model [DEPTH];

  instr_fetch #(.DEPTH(DEPTH), .AW(AW)) dut (
    .SYS_clk     (SYS_clk),
    .SYS_reset   (SYS_reset),
    .load_we     (load_we),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .prog_len    (prog_len),
    .start       (start),
    .stall       (stall),
    .machineCode (machineCode),
    .instr_valid (instr_valid),
    .PC          (PC),
    .busy        (busy),
    .done        (done)
  );

  initial SYS_clk = 1'b0;
  always #5 SYS_clk = ~SYS_clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge SYS_clk);
    #1;
  endtask

  task automatic load_word(input int addr, input logic [31:0] data);
    load_we   = 1'b1;
    load_addr = AW'(addr);
    load_data = data;
    tick();
    load_we   = 1'b0;
    mem_model[addr] = data;
  endtask

  // Random writes and start pulses that the DUT must ignore.
  task automatic drive_noise();
    load_we   = 1'b1;
    load_addr = AW'($urandom_range(0, DEPTH-1));
    load_data = $urandom;
    start     = 1'($urandom_range(0, 1));
  endtask

  // Starts a program and follows it cycle by cycle. mode: 0 no stall,
  // 1 random stalls, 2 two stall cycles while PC=4. vc counts observed valid cycles.
  task automatic run_program(input int plen, input int mode, input bit noise,
                             input string tag, output int vc);
    logic [31:0] exp_q[$];
    logic [66:0] exp_v, act_v;
    int eff, nst;
    vc  = 0;
    eff = (plen > DEPTH) ? DEPTH : plen;
    for (int i = 0; i < eff; i++) begin
      if (mem_model[i] == HALT_WORD) break;
      exp_q.push_back(mem_model[i]);
    end
    prog_len = (AW+1)'(plen);
    if (noise) drive_noise();
    start = 1'b1;
    tick();
    start   = 1'b0;
    load_we = 1'b0;
    if (instr_valid === 1'b1) vc++;
    for (int k = 0; k < exp_q.size(); k++) begin
      exp_v = {1'b1, 1'b0, 1'b1, 32'(k * 4), exp_q[k]};
      if (mode == 1)
        nst = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
      else if (mode == 2 && k == 1)
        nst = 2;
      else
        nst = 0;
      for (int s = 0; s <= nst; s++) begin
        act_v = {busy, done, instr_valid, PC, machineCode};
        checks++;
        if (act_v !== exp_v) begin
          errors++;
          $display("FAIL %s word %0d cycle %0d: got {busy,done,valid,pc,code}=%h expected %h",
                   tag, k, s, act_v, exp_v);
        end
        stall = (s < nst);
        if (noise) drive_noise();
        tick();
        start   = 1'b0;
        load_we = 1'b0;
        if (instr_valid === 1'b1) vc++;
      end
    end
    stall = 1'b0;
    exp_v = {1'b0, 1'b1, 1'b0,
             (exp_q.size() == 0) ? 32'd0 : 32'((exp_q.size() - 1) * 4), 32'd0};
    for (int r = 0; r < 2; r++) begin
      act_v = {busy, done, instr_valid, PC, machineCode};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL %s done[%0d]: got {busy,done,valid,pc,code}=%h expected %h",
                 tag, r, act_v, exp_v);
      end
      if (r == 0) begin
        tick();
        if (instr_valid === 1'b1) vc++;
      end
    end
  endtask

  task automatic test_reset();
    SYS_reset = 1'b1;
    tick();
    tick();
    checks++;
    if ({busy, done, instr_valid, PC, machineCode} !== 67'd0) begin
      errors++;
      $display("FAIL reset: got busy=%b done=%b valid=%b pc=%h code=%h expected all zero",
               busy, done, instr_valid, PC, machineCode);
    end
    SYS_reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int vc;
    for (int i = 0; i < DEPTH; i++) load_word(i, $urandom & 32'h7FFF_FFFF);
    load_word(0, 32'h0022_1820);
    load_word(1, 32'h0022_1822);
    load_word(2, 32'h0022_1824);
    run_program(3, 0, 1'b0, "basic", vc);
    checks++;
    if (vc !== 3) begin
      errors++;
      $display("FAIL basic_count: got %0d valid cycles expected 3", vc);
    end
  endtask

  task automatic test_stall();
    int vc;
    run_program(3, 2, 1'b0, "stall", vc);
    checks++;
    if (vc !== 5) begin
      errors++;
      $display("FAIL stall_count: got %0d valid cycles expected 5", vc);
    end
  endtask

  task automatic test_halt();
    int vc;
    load_word(1, HALT_WORD);
    run_program(4, 0, 1'b0, "halt", vc);
    checks++;
    if (vc !== 1) begin
      errors++;
      $display("FAIL halt_count: got %0d valid cycles expected 1", vc);
    end
    load_word(1, 32'h0022_1822);
  endtask

  task automatic test_len_edges();
    int vc;
    run_program(0, 0, 1'b0, "len0", vc);
    checks++;
    if (vc !== 0) begin
      errors++;
      $display("FAIL len0_count: got %0d valid cycles expected 0", vc);
    end
    run_program(31, 0, 1'b0, "len31", vc);
    checks++;
    if (vc !== 16) begin
      errors++;
      $display("FAIL len31_count: got %0d valid cycles expected 16", vc);
    end
  endtask

  task automatic test_reset_mid_run();
    int vc;
    prog_len = 5'd3;
    start    = 1'b1;
    tick();
    start = 1'b0;
    tick();
    checks++;
    if ({busy, instr_valid, PC, machineCode} !== {1'b1, 1'b1, 32'd4, mem_model[1]}) begin
      errors++;
      $display("FAIL midrun_pre: got busy=%b valid=%b pc=%h code=%h expected busy=1 valid=1 pc=4 code=%h",
               busy, instr_valid, PC, machineCode, mem_model[1]);
    end
    SYS_reset = 1'b1;
    tick();
    SYS_reset = 1'b0;
    checks++;
    if ({busy, done, instr_valid, PC, machineCode} !== 67'd0) begin
      errors++;
      $display("FAIL midrun_reset: got busy=%b done=%b valid=%b pc=%h code=%h expected all zero",
               busy, done, instr_valid, PC, machineCode);
    end
    run_program(3, 0, 1'b0, "after_reset", vc);
    checks++;
    if (vc !== 3) begin
      errors++;
      $display("FAIL after_reset_count: got %0d valid cycles expected 3", vc);
    end
  endtask

  task automatic test_ignored_writes();
    int vc;
    run_program(16, 1, 1'b1, "noisy_run", vc);
    run_program(16, 0, 1'b0, "readback", vc);
    checks++;
    if (vc !== 16) begin
      errors++;
      $display("FAIL readback_count: got %0d valid cycles expected 16", vc);
    end
  endtask

  task automatic test_random();
    int vc;
    for (int it = 0; it < 25; it++) begin
      for (int w = 0; w < 3; w++) begin
        if ($urandom_range(0, 5) == 0)
          load_word($urandom_range(1, DEPTH-1), HALT_WORD);
        else
          load_word($urandom_range(0, DEPTH-1), $urandom & 32'h7FFF_FFFF);
      end
      run_program($urandom_range(0, 20), 1, 1'($urandom_range(0, 1)), "random", vc);
    end
  endtask

  initial begin
    SYS_reset = 1'b0;
    load_we   = 1'b0;
    load_addr = '0;
    load_data = '0;
    prog_len  = '0;
    start     = 1'b0;
    stall     = 1'b0;
    test_reset();
    test_basic();
    test_stall();
    test_halt();
    test_len_edges();
    test_reset_mid_run();
    test_ignored_writes();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
